// File: rtl/control_unit_if.sv
// control_unit_if: control and memory-handshake bundle between the sequencer and the datapath/memory side.
interface control_unit_if;
  logic [15:0] Instruction;
  logic        Status;
  logic        mem_ack;
  logic [8:0]  LoadSignal;
  logic [5:0]  TransferSignal;
  logic [2:0]  ALOP;
  logic        mem_rd;
  logic        mem_wr;
  logic        halted;
  logic        illegal;
  modport master (
    input  Instruction, Status, mem_ack,
    output LoadSignal, TransferSignal, ALOP, mem_rd, mem_wr, halted, illegal
  );
  modport slave (
    output Instruction, Status, mem_ack,
    input  LoadSignal, TransferSignal, ALOP, mem_rd, mem_wr, halted, illegal
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer for the 16-bit stack CPU.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky illegal flag.
module control_unit #(
  parameter logic [2:0] ALU_PASS = 3'b000,
  parameter logic [2:0] ALU_INC  = 3'b001,
  parameter logic [2:0] ALU_DEC  = 3'b010,
  parameter logic [2:0] ALU_ADD  = 3'b011
) (
  input logic clk,
  input logic reset,
  control_unit_if.master bus
);
  localparam logic [4:0] F0 = 5'd0, F1 = 5'd1, F2 = 5'd2, DEC = 5'd3;
  localparam logic [4:0] P0 = 5'd4, P1 = 5'd5, P2 = 5'd6, P3 = 5'd7;
  localparam logic [4:0] Q0 = 5'd8, Q1 = 5'd9, Q2 = 5'd10, Q3 = 5'd11;
  localparam logic [4:0] A0 = 5'd12, A1 = 5'd13, A2 = 5'd14, A3 = 5'd15;
  localparam logic [4:0] A4 = 5'd16, A5 = 5'd17, A6 = 5'd18, A7 = 5'd19;
  localparam logic [4:0] B0 = 5'd20, B1 = 5'd21, HALT = 5'd22;
  localparam logic [8:0] LD_R = 9'h001, LD_PC = 9'h002, LD_SP = 9'h004, LD_F = 9'h008, LD_T = 9'h010;
  localparam logic [8:0] LD_MAR = 9'h020, LD_MDM = 9'h040, LD_MDZ = 9'h080, LD_IR = 9'h100;
  localparam logic [5:0] TR_R = 6'h01, TR_PC = 6'h02, TR_SP = 6'h04, TR_MDR = 6'h10, TR_L = 6'h20;
  logic [4:0] state, next_state;
  logic [2:0] op;
  logic       ack, ill_q;
  logic [8:0] ld;
  logic [5:0] tr;
  logic [2:0] alop;
  logic       rd, wr;
  assign op  = bus.Instruction[14:12];
  assign ack = bus.mem_ack;
`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
  always_ff @(posedge clk)
    ill_q <= reset ? 1'b0 : ill_q | (state == DEC && !bus.Instruction[15] && op[2] && op[1:0] != 2'b00);
`else
  localparam logic TRAP_EN = 1'b0;
  assign ill_q = 1'b0;
`endif
  always_comb begin
    next_state = state;
    case (state)
      F0:         next_state = F1;
      F1:         next_state = ack ? F2 : F1;
      F2:         next_state = DEC;
      DEC:        next_state = bus.Instruction[15] ? (bus.Status ? B0 : F0) :
                               (op == 3'b000 || op == 3'b011) ? P0 :
                               op == 3'b001 ? Q0 :
                               op == 3'b010 ? A0 :
                               (op == 3'b100 || TRAP_EN) ? HALT : F0;
      P3, A7:     next_state = ack ? F0 : state;
      Q1, A1, A5: next_state = ack ? state + 5'd1 : state;
      Q3, B1:     next_state = F0;
      HALT:       next_state = HALT;
      default:    next_state = state + 5'd1;
    endcase
  end
  // ldIR/ldMDM are the only outputs qualified by the ack; everything else is pure state decode
  always_comb begin
    ld   = '0;
    tr   = '0;
    alop = ALU_PASS;
    rd   = 1'b0;
    wr   = 1'b0;
    case (state)
      F0:                 begin tr = TR_PC; ld = LD_MAR; end
      F1:                 begin rd = 1'b1; ld = ack ? LD_IR : '0; end
      F2:                 begin tr = TR_PC; alop = ALU_INC; ld = LD_PC; end
      P0:                 begin tr = TR_SP; alop = ALU_DEC; ld = LD_SP; end
      P1, Q0, A0, A4:     begin tr = TR_SP; ld = LD_MAR; end
      P2:                 begin tr = (op == 3'b011) ? TR_L : TR_R; ld = LD_MDZ; end
      P3, A7:             wr = 1'b1;
      Q1, A1, A5:         begin rd = 1'b1; ld = ack ? LD_MDM : '0; end
      Q2:                 begin tr = TR_MDR; ld = LD_R; end
      Q3, A3:             begin tr = TR_SP; alop = ALU_INC; ld = LD_SP; end
      A2:                 begin tr = TR_MDR; ld = LD_T; end
      A6:                 begin tr = TR_MDR; alop = bus.Instruction[2:0]; ld = LD_MDZ | LD_F; end
      B0:                 begin tr = TR_PC; ld = LD_T; end
      B1:                 begin tr = TR_L; alop = ALU_ADD; ld = LD_PC; end
      default:            ;
    endcase
  end
  always_ff @(posedge clk)
    state <= reset ? F0 : next_state;
  assign bus.LoadSignal     = reset ? '0 : ld;
  assign bus.TransferSignal = reset ? '0 : tr;
  assign bus.ALOP           = reset ? '0 : alop;
  assign bus.mem_rd         = !reset && rd;
  assign bus.mem_wr         = !reset && wr;
  assign bus.halted         = !reset && state == HALT;
  assign bus.illegal        = !reset && ill_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction streams with random memory wait states, scoreboarded per cycle.
module tb_control_unit;
  localparam logic [8:0] LD_R = 9'h001, LD_PC = 9'h002, LD_SP = 9'h004, LD_F = 9'h008, LD_T = 9'h010;
  localparam logic [8:0] LD_MAR = 9'h020, LD_MDM = 9'h040, LD_MDZ = 9'h080, LD_IR = 9'h100;
  localparam logic [5:0] TR_R = 6'h01, TR_PC = 6'h02, TR_SP = 6'h04, TR_MDR = 6'h10, TR_L = 6'h20;
  localparam logic [2:0] PASS = 3'd0, INC = 3'd1, DECR = 3'd2, ADD = 3'd3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passes = 0;
  logic [21:0] exp_q[$];
  bit fetch_q[$];
  always #5 clk = ~clk;
  control_unit_if bus();
  control_unit dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [21:0] dut_vec();
    return {bus.halted, bus.illegal, bus.LoadSignal, bus.TransferSignal, bus.ALOP, bus.mem_rd, bus.mem_wr};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at %0t: got %h expected %h (ir %h)", name, $time, act, req, bus.Instruction);
  endtask

  task automatic step(input logic [8:0] ld, input logic [5:0] tr, input logic [2:0] op);
    exp_q.push_back({2'b00, ld, tr, op, 2'b00});
  endtask

  task automatic req(input logic [8:0] ld, input bit wr, input bit fetch);
    exp_q.push_back({2'b00, ld, 9'h000, ~wr, wr});
    fetch_q.push_back(fetch);
  endtask

  task automatic fetch_start();
    step(LD_MAR, TR_PC, PASS);
    req(LD_IR, 1'b0, 1'b1);
  endtask

  task automatic halt_steps(input logic il);
    repeat (5) exp_q.push_back({1'b1, il, 20'h0});
  endtask

  // Expected per-cycle behaviour of one instruction, from the cycle after its fetch read completes
  task automatic model(input logic [15:0] ir, input logic st, output bit cont);
    logic [2:0] op;
    op = ir[14:12];
    cont = 1'b1;
    step(LD_PC, TR_PC, INC);
    step(9'h000, 6'h00, PASS);
    if (ir[15]) begin
      if (st) begin
        step(LD_T, TR_PC, PASS);
        step(LD_PC, TR_L, ADD);
      end
    end else if (op == 3'd0 || op == 3'd3) begin
      step(LD_SP, TR_SP, DECR);
      step(LD_MAR, TR_SP, PASS);
      step(LD_MDZ, op == 3'd3 ? TR_L : TR_R, PASS);
      req(9'h000, 1'b1, 1'b0);
    end else if (op == 3'd1) begin
      step(LD_MAR, TR_SP, PASS);
      req(LD_MDM, 1'b0, 1'b0);
      step(LD_R, TR_MDR, PASS);
      step(LD_SP, TR_SP, INC);
    end else if (op == 3'd2) begin
      step(LD_MAR, TR_SP, PASS);
      req(LD_MDM, 1'b0, 1'b0);
      step(LD_T, TR_MDR, PASS);
      step(LD_SP, TR_SP, INC);
      step(LD_MAR, TR_SP, PASS);
      req(LD_MDM, 1'b0, 1'b0);
      step(LD_MDZ | LD_F, TR_MDR, ir[2:0]);
      req(9'h000, 1'b1, 1'b0);
    end else if (op == 3'd4) begin
      cont = 1'b0;
      halt_steps(1'b0);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      cont = 1'b0;
      halt_steps(1'b1);
`endif
    end
    if (cont) fetch_start();
  endtask

  function automatic logic [15:0] gen();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 9: return {4'b0000, r[11:0]};
      2:       return {4'b0001, r[11:0]};
      3, 4:    return {4'b0010, r[11:0]};
      5:       return {4'b0011, r[11:0]};
      6, 7:    return {1'b1, r[14:0]};
      default: return {1'b0, 3'(5 + $urandom_range(0, 2)), r[11:0]};
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ack = 1'b0;
    exp_q.delete();
    fetch_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", dut_vec(), '0);
    fetch_start();
    reset = 1'b0;
  endtask

  // Plays memory and datapath: acks requests after random waits and feeds IR/Status after each fetch
  task automatic run_program(input int n, input bit abort, input logic [15:0] first);
    int fetched = 0;
    int wait_left = 0;
    bit is_f, cont;
    bit ended = 1'b0;
    bit finished = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      is_f = 1'b0;
      if (bus.mem_rd || bus.mem_wr) begin
        if (abort && bus.mem_wr) begin
          bus.mem_ack = 1'b0;
          reset = 1'b1;
          #1;
          check("abort_drop", dut_vec(), '0);
          return;
        end
        if (wait_left > 0) begin
          bus.mem_ack = 1'b0;
          wait_left--;
        end else begin
          bus.mem_ack = 1'b1;
          wait_left = $urandom_range(0, 3);
          if (fetch_q.size() > 0) is_f = fetch_q.pop_front();
        end
      end else bus.mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (is_f) begin
        fetched++;
        bus.Instruction = fetched == 1 ? first : fetched >= n ? 16'h4000 : gen();
        bus.Status = 1'($urandom_range(0, 1));
        model(bus.Instruction, bus.Status, cont);
        ended = !cont;
      end
      finished = ended && exp_q.size() == 0;
    end
    if (!finished) begin
      checks++;
      $display("FAIL timeout: program unfinished, %0d steps left", exp_q.size());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL queue_empty at %0t: got %h expected nothing", $time, dut_vec());
        end else if ((exp_q[0][1] || exp_q[0][0]) && !bus.mem_ack)
          check("wait_hold", dut_vec(), exp_q[0] & ~22'h0A0000);
        else
          check("step", dut_vec(), exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.Instruction = 16'h0000;
    bus.Status = 1'b0;
    bus.mem_ack = 1'b0;
    run_program(12, 1'b0, 16'h0010);
    run_program(12, 1'b0, 16'h2003);
    run_program(10, 1'b0, 16'h8FFE);
    run_program(10, 1'b0, 16'h5000);
    run_program(6, 1'b1, 16'h0010);
    run_program(40, 1'b0, 16'h3ABC);
    for (int i = 0; i < 4; i++) run_program(25, 1'b0, gen());
    reset = 1'b1;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
